// File: rtl/dna_id_matcher_if.sv
// dna_id_matcher_if: bus between the ID matcher, its serial ID source and the boot logic
// Parameters: DNA_WIDTH identifier bits, NUM_IDS expected slots, IDX_W match index width
// Requester side: start, expected_ids, id_enable. Source side: dna_read, dna_shift, dna_dout.
// Results: busy, done, match, match_idx, dna_value.
// slave is the matcher's view; master is the view of whatever surrounds it.
interface dna_id_matcher_if #(
  parameter int DNA_WIDTH = 57,
  parameter int NUM_IDS   = 4,
  parameter int IDX_W     = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1
);
  logic                         start;
  logic [NUM_IDS*DNA_WIDTH-1:0] expected_ids;
  logic [NUM_IDS-1:0]           id_enable;
  logic                         dna_read;
  logic                         dna_shift;
  logic                         dna_dout;
  logic                         busy;
  logic                         done;
  logic                         match;
  logic [IDX_W-1:0]             match_idx;
  logic [DNA_WIDTH-1:0]         dna_value;
  modport slave (
    input  start, expected_ids, id_enable, dna_dout,
    output dna_read, dna_shift, busy, done, match, match_idx, dna_value
  );
  modport master (
    output start, expected_ids, id_enable, dna_dout,
    input  dna_read, dna_shift, busy, done, match, match_idx, dna_value
  );
endinterface

// File: rtl/dna_id_matcher.sv
// dna_id_matcher: reads a serial device identifier and matches it against enabled expected IDs
// Ports: clk, reset_n (async active-low), bus (dna_id_matcher_if.slave).
// Reads automatically once after reset and again on start in IDLE/DONE.
// DNA_LOCK_EN: when defined, the first result is frozen and start is ignored until reset.
module dna_id_matcher #(
  parameter int DNA_WIDTH = 57,
  parameter int NUM_IDS   = 4,
  parameter int IDX_W     = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1
) (
  input logic              clk,
  input logic              reset_n,
  dna_id_matcher_if.slave  bus
);
  localparam int CW = $clog2(DNA_WIDTH);
`ifdef DNA_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, COMPARE, DONE} state_t;
  state_t               state_q, state_d;
  logic                 pend_q, pend_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DNA_WIDTH-1:0] val_q, val_d;
  logic                 match_q, match_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 hit_any;
  logic [IDX_W-1:0]     hit_idx;
  logic                 go;
  // Scanning from the top down leaves the lowest matching slot as the winner.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_IDS - 1; i >= 0; i--)
      if (bus.id_enable[i] && bus.expected_ids[i*DNA_WIDTH +: DNA_WIDTH] == val_q) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
  end
  assign go = (state_q == IDLE && (pend_q || bus.start)) || (state_q == DONE && bus.start && !LOCK);
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    match_d = match_q;
    idx_d   = idx_q;
    if (go) begin
      state_d = LOAD;
      pend_d  = 1'b0;
      val_d   = '0;
      match_d = 1'b0;
      idx_d   = '0;
    end else begin
      case (state_q)
        LOAD: begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
        SHIFT: begin
          val_d   = {val_q[DNA_WIDTH-2:0], bus.dna_dout};
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == CW'(DNA_WIDTH - 1)) ? COMPARE : SHIFT;
        end
        COMPARE: begin
          match_d = hit_any;
          idx_d   = hit_idx;
          state_d = DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      pend_q  <= 1'b1;
      cnt_q   <= '0;
      val_q   <= '0;
      match_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      match_q <= match_d;
      idx_q   <= idx_d;
    end
  // Strobes decode straight from the state register, so they are mutually exclusive and reset async.
  assign bus.dna_read  = state_q == LOAD;
  assign bus.dna_shift = state_q == SHIFT;
  assign bus.busy      = state_q == LOAD || state_q == SHIFT || state_q == COMPARE;
  assign bus.done      = state_q == DONE;
  assign bus.match     = match_q;
  assign bus.match_idx = idx_q;
  assign bus.dna_value = val_q;
endmodule

// File: tb/tb_dna_id_matcher.sv
// tb_dna_id_matcher: directed checks of read timing, matching, priority, reset and re-start
module tb_dna_id_matcher;
  localparam int W = 57;
  localparam logic [W-1:0] SRC = 57'h028340E18D8C85C;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int reads = 0;
  int ovl = 0;
  int n;
  int r0;
  logic [W-1:0] src_q = '0;
  logic [W-1:0] held;
  dna_id_matcher_if #(.DNA_WIDTH(W), .NUM_IDS(4)) bus ();
  dna_id_matcher #(.DNA_WIDTH(W), .NUM_IDS(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.dna_read) src_q <= SRC;
    else if (bus.dna_shift) src_q <= {src_q[W-2:0], 1'b0};
    if (bus.dna_read) reads <= reads + 1;
    if (bus.dna_read && bus.dna_shift) ovl <= ovl + 1;
  end
  assign bus.dna_dout = src_q[W-1];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic st, input int pulse, output int cnt);
    bus.start = st;
    cnt = 0;
    while (cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
      bus.start = (cnt == pulse);
      if (bus.done) break;
    end
    bus.start = 1'b0;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.id_enable = 4'hF;
    bus.expected_ids = {SRC ^ 57'h4, SRC ^ 57'h2, SRC ^ 57'h1, SRC};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_strobes", {bus.dna_read, bus.dna_shift}, 0);
    chk("rst_match", {bus.match, bus.match_idx}, 0);
    chk("rst_value", bus.dna_value, 0);
    reset_n = 1'b1;
    run(1'b0, 0, n);
    chk("auto_latency", n, 60);
    chk("auto_match", bus.match, 1);
    chk("auto_idx", bus.match_idx, 0);
    chk("auto_value", bus.dna_value, SRC);
    chk("auto_busy", bus.busy, 0);
    bus.expected_ids = {SRC ^ 57'h4, SRC, SRC ^ 57'h2, SRC ^ 57'h1};
    run(1'b1, 0, n);
    chk("slot2_latency", n, 60);
    chk("slot2_match", bus.match, 1);
    chk("slot2_idx", bus.match_idx, 2);
    bus.id_enable = 4'b1011;
    run(1'b1, 0, n);
    chk("dis_match", bus.match, 0);
    chk("dis_idx", bus.match_idx, 0);
    bus.id_enable = 4'hF;
    bus.expected_ids = {SRC, SRC ^ 57'h8, SRC, SRC ^ 57'h1};
    run(1'b1, 0, n);
    chk("dup_match", bus.match, 1);
    chk("dup_idx", bus.match_idx, 1);
    bus.id_enable = 4'b0101;
    #20;
    chk("held_idx", bus.match_idx, 1);
    bus.id_enable = 4'hF;
    r0 = reads;
    run(1'b1, 22, n);
    chk("busy_start_latency", n, 60);
    chk("busy_start_reads", reads - r0, 1);
    chk("busy_start_idx", bus.match_idx, 1);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    chk("mid_shift", bus.dna_shift, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_match", bus.match, 0);
    chk("arst_value", bus.dna_value, 0);
    chk("arst_shift", bus.dna_shift, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run(1'b0, 0, n);
    chk("rerun_latency", n, 60);
    chk("rerun_value", bus.dna_value, SRC);
    chk("rerun_idx", bus.match_idx, 1);
    held = bus.dna_value;
    r0 = reads;
`ifdef DNA_LOCK_EN
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    chk("lock_reads", reads - r0, 0);
    chk("lock_done", bus.done, 1);
    chk("lock_value", bus.dna_value, held);
`else
    run(1'b1, 0, n);
    chk("restart_latency", n, 60);
    chk("restart_reads", reads - r0, 1);
    chk("restart_value", bus.dna_value, held);
`endif
    chk("no_overlap", ovl, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
